// File: rtl/ntt_butterfly_unit_pkg.sv
// ntt_butterfly_unit_pkg: Kyber modulus constants and canonical mod-q add/sub helpers
`timescale 1ns/1ps
package ntt_butterfly_unit_pkg;
   localparam int W = 12;
   localparam logic [W:0] Q = 13'd3329;
   localparam logic [W:0] BARRETT_K = 13'd5039;
   localparam int BARRETT_SHIFT = 24;
   typedef logic [W-1:0] coef_t;
   function automatic coef_t mod_add(input coef_t a, input coef_t b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      s = (s >= Q) ? s - Q : s;
      return s[W-1:0];
   endfunction
   // bit W of the 13-bit difference is the borrow of a - b
   function automatic coef_t mod_sub(input coef_t a, input coef_t b);
      logic [W:0] d;
      d = {1'b0, a} - {1'b0, b};
      d = d[W] ? d + Q : d;
      return d[W-1:0];
   endfunction
endpackage

// File: rtl/ntt_butterfly_unit_mod_q_mul_const.sv
// ntt_butterfly_unit_mod_q_mul_const: two-stage zeta*x mod q (multiply, then Barrett reduce)
`timescale 1ns/1ps
module ntt_butterfly_unit_mod_q_mul_const import ntt_butterfly_unit_pkg::*; #(
   parameter coef_t ZETA = 12'd2
) (
   input  logic         clk,
   input  logic         r,
   input  logic [W-1:0] x,
   output logic [W-1:0] t
);
   logic [2*W-1:0] p;
   logic [W:0] qhat, qq, rem;
   // quotient estimate is low by at most one, so rem lies in [0, 2q)
   always_comb begin
      qhat = (W+1)'(({{(W+1){1'b0}}, p} * {{(2*W){1'b0}}, BARRETT_K}) >> BARRETT_SHIFT);
      qq = qhat * Q;
      rem = p[W:0] - qq;
   end
   always_ff @(posedge clk or negedge r)
      if (!r) begin
         p <= '0;
         t <= '0;
      end else begin
         p <= {{W{1'b0}}, x} * {{W{1'b0}}, ZETA};
         t <= W'((rem >= Q) ? rem - Q : rem);
      end
endmodule

// File: rtl/ntt_butterfly_unit.sv
// ntt_butterfly_unit: 4-stage Kyber CT/GS butterfly with per-sample mode select
`timescale 1ns/1ps
module ntt_butterfly_unit import ntt_butterfly_unit_pkg::*; #(
   parameter logic [11:0] twiddle = 12'd2
) (
   input  logic         clk,
   input  logic         r,
   input  logic [W-1:0] IN_1,
   input  logic [W-1:0] IN_2,
   input  logic         valid_in,
   input  logic         inverse,
   output logic [W-1:0] U_OUT,
   output logic [W-1:0] V_OUT,
   output logic         valid_out
);
   logic [2:0][W-1:0] delay_pipe, s_pipe;
   logic [W-1:0] b_q, d_q, t;
   logic inverse_pipe [4];
   logic [3:0] valid_pipe;
   ntt_butterfly_unit_mod_q_mul_const #(.ZETA(twiddle)) mul (
      .clk(clk),
      .r(r),
      .x(inverse_pipe[0] ? d_q : b_q),
      .t(t)
   );
   always_ff @(posedge clk or negedge r)
      if (!r) begin
         delay_pipe <= '0;
         s_pipe <= '0;
         b_q <= '0;
         d_q <= '0;
         valid_pipe <= '0;
         U_OUT <= '0;
         V_OUT <= '0;
         for (int i = 0; i < 4; i++) inverse_pipe[i] <= 1'b0;
      end else begin
         delay_pipe <= {delay_pipe[1:0], IN_1};
         s_pipe <= {s_pipe[1:0], mod_add(IN_1, IN_2)};
         b_q <= IN_2;
         d_q <= mod_sub(IN_1, IN_2);
         valid_pipe <= {valid_pipe[2:0], valid_in};
         inverse_pipe[0] <= inverse;
         for (int i = 1; i < 4; i++) inverse_pipe[i] <= inverse_pipe[i-1];
         U_OUT <= inverse_pipe[2] ? s_pipe[2] : mod_add(delay_pipe[2], t);
         V_OUT <= inverse_pipe[2] ? t : mod_sub(delay_pipe[2], t);
      end
   assign valid_out = valid_pipe[3];
endmodule

// File: tb/tb_ntt_butterfly_unit.sv
// tb_ntt_butterfly_unit: directed and randomized checks of the mod-q butterfly pipeline
`timescale 1ns/1ps
module tb_ntt_butterfly_unit;
   localparam int QM = 3329;
   localparam int Z = 2;
   localparam int LAT = 4;
   logic clk = 1'b0;
   logic r = 1'b0;
   logic valid_in = 1'b0;
   logic inverse = 1'b0;
   logic [11:0] IN_1 = '0;
   logic [11:0] IN_2 = '0;
   logic [11:0] U_OUT, V_OUT;
   logic valid_out;
   int tests = 0;
   int fails = 0;
   int cyc = LAT;
   logic hv [2048];
   logic [11:0] hu [2048];
   logic [11:0] hw [2048];

   always #5 clk = ~clk;

   ntt_butterfly_unit #(.twiddle(12'(Z))) dut (
      .clk(clk),
      .r(r),
      .IN_1(IN_1),
      .IN_2(IN_2),
      .valid_in(valid_in),
      .inverse(inverse),
      .U_OUT(U_OUT),
      .V_OUT(V_OUT),
      .valid_out(valid_out)
   );

   function automatic void model(input logic inv, input int a, input int b, output int u, output int v);
      int t;
      if (!inv) begin
         t = (Z * b) % QM;
         u = (a + t) % QM;
         v = (a - t + QM) % QM;
      end else begin
         u = (a + b) % QM;
         v = (Z * ((a - b + QM) % QM)) % QM;
      end
   endfunction

   task automatic check_zero(input string tag);
      tests++;
      assert (valid_out === 1'b0) else begin fails++; $error("FAIL %s valid_out got=%b exp=0", tag, valid_out); end
      tests++;
      assert (U_OUT === 12'd0) else begin fails++; $error("FAIL %s U_OUT got=%0d exp=0", tag, U_OUT); end
      tests++;
      assert (V_OUT === 12'd0) else begin fails++; $error("FAIL %s V_OUT got=%0d exp=0", tag, V_OUT); end
   endtask

   task automatic step(input logic v, input logic inv, input int a, input int b, input int eu, input int ew);
      int k;
      @(posedge clk);
      #1;
      k = cyc - LAT;
      tests++;
      assert (valid_out === hv[k]) else begin fails++; $error("FAIL valid_out cyc=%0d got=%b exp=%b", cyc, valid_out, hv[k]); end
      if (hv[k]) begin
         tests++;
         assert (U_OUT === hu[k]) else begin fails++; $error("FAIL U_OUT cyc=%0d got=%0d exp=%0d", cyc, U_OUT, hu[k]); end
         tests++;
         assert (V_OUT === hw[k]) else begin fails++; $error("FAIL V_OUT cyc=%0d got=%0d exp=%0d", cyc, V_OUT, hw[k]); end
      end
      valid_in = v;
      inverse = inv;
      IN_1 = 12'(a);
      IN_2 = 12'(b);
      hv[cyc] = v;
      hu[cyc] = 12'(eu);
      hw[cyc] = 12'(ew);
      cyc++;
   endtask

   task automatic rnd_step(input logic v, input logic inv);
      int a, b, u, w;
      a = int'($urandom_range(0, QM - 1));
      b = int'($urandom_range(0, QM - 1));
      model(inv, a, b, u, w);
      step(v, inv, a, b, u, w);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) begin
         hv[i] = 1'b0;
         hu[i] = '0;
         hw[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      r = 1'b1;
      step(1'b1, 1'b0, 100, 200, 500, 3029);
      step(1'b1, 1'b0, 3328, 3328, 3326, 1);
      step(1'b1, 1'b0, 0, 0, 0, 0);
      step(1'b1, 1'b1, 5, 10, 15, 3319);
      step(1'b1, 1'b1, 3000, 1000, 671, 671);
      idle(LAT + 1);
      for (int i = 0; i < 500; i++) rnd_step(1'b1, 1'(i % 2));
      idle(LAT + 1);
      rnd_step(1'b1, 1'b0);
      rnd_step(1'b0, 1'b1);
      rnd_step(1'b1, 1'b1);
      rnd_step(1'b1, 1'b0);
      rnd_step(1'b0, 1'b0);
      idle(LAT + 1);
      for (int i = 0; i < 6; i++) rnd_step(1'b1, 1'(i % 2));
      #2 r = 1'b0;
      #1 check_zero("rst_mid");
      for (int i = 1; i <= LAT; i++) hv[cyc - i] = 1'b0;
      valid_in = 1'b0;
      idle(2);
      #2 r = 1'b1;
      idle(3);
      rnd_step(1'b1, 1'b1);
      rnd_step(1'b1, 1'b0);
      idle(LAT + 2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
